branch_resolve_queue: RTL
=========================

Name: branch_resolve_queue

Overview:
- Tracks every in-flight conditional branch between fetch-time prediction and execute-time resolution.
- Fetch allocates an entry carrying the predictor's PHT index, predicted direction and GHR snapshot. Execute resolves entries by tag, in any order.
- Entries retire strictly in program order. Each retirement drives the PHT update (index, actual outcome) back into the branch predictor.
- A wrong prediction raises a one-cycle mispredict with the corrected GHR and flushes all younger entries.

Parameters:
- DEPTH, 8, number of queue entries (power of two)
- TAG_W, 3, log2(DEPTH), tag width
- IDX_W, 5, PHT index width
- GHR_W, 3, global history register width

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- alloc_valid  in  1  fetch presents a conditional branch
- alloc_pht_index  in  IDX_W  predictor PHT index used for this branch
- alloc_pred_taken  in  1  predicted direction
- alloc_ghr  in  GHR_W  GHR value at prediction time
- alloc_ready  out  1  queue accepts an allocation this cycle
- alloc_tag  out  TAG_W  tag given to the allocating branch (current tail pointer)
- res_valid  in  1  execute resolves a branch
- res_tag  in  TAG_W  tag being resolved
- res_taken  in  1  actual outcome
- upd_valid  out  1  PHT update strobe to predictor
- upd_pht_index  out  IDX_W  PHT index to update
- upd_taken  out  1  actual outcome for update
- mispredict  out  1  one-cycle flush pulse
- restore_ghr  out  GHR_W  corrected GHR; valid when mispredict=1
- count  out  TAG_W+1  occupied entries

Behaviour:
- Reset (reset=1 at posedge): head=tail=0, count=0, all entry valid/resolved bits cleared. Outputs upd_valid, upd_pht_index, upd_taken, mispredict and restore_ghr are 0. A reset mid-operation discards all entries; no update is emitted.
- Storage: circular buffer. Each entry holds {valid, resolved, pht_index, pred, actual, ghr}. Head and tail are TAG_W bits wide and wrap modulo DEPTH. Full/empty is taken from count, not from pointer compare.
- Allocate:
  - Occurs when alloc_valid && alloc_ready at a posedge.
  - Writes the entry at tail, sets valid=1, resolved=0, increments tail.
  - alloc_tag = tail, combinationally.
  - alloc_ready = (count != DEPTH) && !flush_now.
- Resolve:
  - On res_valid at a posedge where entry[res_tag] is valid and not resolved: set resolved=1 and actual=res_taken.
  - A resolve to an invalid or already-resolved entry is ignored.
- Retire:
  - Combinational condition: head entry valid && resolved. At most one retire per cycle.
  - At that posedge: clear the entry, increment head, register upd_valid=1, upd_pht_index=entry.pht_index, upd_taken=entry.actual.
  - Update outputs are registered, so a resolve at edge N produces retire at edge N+1 and upd_valid high in the cycle after N+1.
- Mispredict:
  - flush_now = retire condition && actual != pred.
  - At that edge, also register mispredict=1 and restore_ghr={ghr[GHR_W-2:0], actual}.
  - Clear all entries, set tail=head+1 (queue empty) and count=0.
  - Any allocation or resolve presented in the same cycle is dropped.
- upd_valid and mispredict are single-cycle pulses, deasserted in any cycle without a retire.
- Count: +1 on allocate, −1 on retire, unchanged on both, 0 on flush.
- Full: no allocation while count==DEPTH. This holds even if a retire occurs in the same cycle; there is no same-cycle bypass.

Optional Feature:
- Macro: BRQ_STATS_EN.
- Defined: adds outputs stat_retired[31:0] and stat_mispred[31:0]. These are saturating counters of retirements and of mispredicted retirements, cleared on reset, updated at the retire edge.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (brq_pkg):
  - width constants IDX_W, GHR_W and default DEPTH
  - entry struct typedef {valid, resolved, pht_index, pred, actual, ghr}
- One natural sub-module, brq_stats: the two saturating counters, instantiated only under BRQ_STATS_EN.
- Pointer, count and flush logic stay in the top module.

Test Plan:
- Single branch, correct prediction:
  - Stimulus: alloc(idx=5'h0A, pred=1, ghr=3'b010) → tag 0; resolve tag 0 taken=1.
  - Response: upd_valid=1, upd_pht_index=0A, upd_taken=1 two edges after resolve; mispredict=0; count 1→0.
- Mispredict flush:
  - Stimulus: alloc tags 0,1,2; resolve tag 0 taken=0 with pred=1, ghr=3'b011.
  - Response: mispredict=1, restore_ghr=3'b110, upd_taken=0; count=0; a later resolve of tag 1 is ignored.
- Out-of-order resolve:
  - Stimulus: alloc tags 0,1; resolve tag 1 then tag 0.
  - Response: two update pulses on consecutive cycles, order idx(tag0) then idx(tag1).
- Full and wrap:
  - Stimulus: 8 allocates.
  - Response: alloc_ready=0 and count=8.
  - Stimulus: resolve and retire tag 0, then allocate.
  - Response: new alloc_tag=0 (wrap); count=8 again.
- Simultaneous events:
  - Stimulus: alloc in the same cycle as a correct retire at count=4.
  - Response: count stays 4.
  - Stimulus: alloc in the same cycle as a mispredict retire.
  - Response: alloc dropped; count=0.
- Reset mid-operation:
  - Stimulus: 3 entries (one resolved), assert reset.
  - Response: count=0, upd_valid=0, mispredict=0, alloc_tag=0 on the next cycle.

Source files
------------

// File: rtl/brq_pkg.sv
// brq_pkg: shared widths and entry layout for the branch resolve queue.
package brq_pkg;
    localparam int IDX_W     = 5;
    localparam int GHR_W     = 3;
    localparam int DEPTH_DEF = 8;

    typedef struct packed {
        logic             valid;
        logic             resolved;
        logic [IDX_W-1:0] pht_index;
        logic             pred;
        logic             actual;
        logic [GHR_W-1:0] ghr;
    } entry_t;
endpackage

// File: rtl/brq_stats.sv
// brq_stats: saturating retirement and mispredict counters (used only with BRQ_STATS_EN).
module brq_stats (
    input  logic        clock,
    input  logic        reset,
    input  logic        retire,
    input  logic        mispred,
    output logic [31:0] stat_retired,
    output logic [31:0] stat_mispred
);
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_retired <= '0;
            stat_mispred <= '0;
        end else begin
            if (retire && stat_retired != '1) stat_retired <= stat_retired + 32'd1;
            if (mispred && stat_mispred != '1) stat_mispred <= stat_mispred + 32'd1;
        end
    end
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order retirement of predicted branches with PHT update and mispredict flush.
// Define BRQ_STATS_EN to add the stat_retired/stat_mispred counter outputs.
module branch_resolve_queue
    import brq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_valid,
    input  logic [IDX_W-1:0] alloc_pht_index,
    input  logic             alloc_pred_taken,
    input  logic [GHR_W-1:0] alloc_ghr,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    output logic             upd_valid,
    output logic [IDX_W-1:0] upd_pht_index,
    output logic             upd_taken,
    output logic             mispredict,
    output logic [GHR_W-1:0] restore_ghr,
    output logic [TAG_W:0]   count
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]      stat_retired,
    output logic [31:0]      stat_mispred
`endif
);
    entry_t           q [DEPTH];
    entry_t           hd;
    logic [TAG_W-1:0] head, tail;
    logic             retire, flush_now, do_alloc, do_res;

    assign hd          = q[head];
    assign retire      = hd.valid && hd.resolved;
    assign flush_now   = retire && (hd.actual != hd.pred);
    assign alloc_ready = (count != (TAG_W+1)'(DEPTH)) && !flush_now;
    assign alloc_tag   = tail;
    assign do_alloc    = alloc_valid && alloc_ready;
    assign do_res      = res_valid && q[res_tag].valid && !q[res_tag].resolved;

    always_ff @(posedge clock) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            upd_valid     <= 1'b0;
            upd_pht_index <= '0;
            upd_taken     <= 1'b0;
            mispredict    <= 1'b0;
            restore_ghr   <= '0;
        end else begin
            upd_valid  <= retire;
            mispredict <= flush_now;
            if (retire) begin
                upd_pht_index <= hd.pht_index;
                upd_taken     <= hd.actual;
                head          <= head + TAG_W'(1);
            end
            // A flush empties the queue just past the mispredicted branch and drops same-cycle alloc/resolve
            if (flush_now) begin
                restore_ghr <= {hd.ghr[GHR_W-2:0], hd.actual};
                for (int i = 0; i < DEPTH; i++) q[i] <= '0;
                tail        <= head + TAG_W'(1);
                count       <= '0;
            end else begin
                if (do_res) begin
                    q[res_tag].resolved <= 1'b1;
                    q[res_tag].actual   <= res_taken;
                end
                if (do_alloc) begin
                    q[tail] <= '{valid: 1'b1, resolved: 1'b0, pht_index: alloc_pht_index,
                                 pred: alloc_pred_taken, actual: 1'b0, ghr: alloc_ghr};
                    tail    <= tail + TAG_W'(1);
                end
                if (retire) q[head] <= '0;
                count <= count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(retire);
            end
        end
    end

`ifdef BRQ_STATS_EN
    brq_stats u_stats (
        .clock        (clock),
        .reset        (reset),
        .retire       (retire),
        .mispred      (flush_now),
        .stat_retired (stat_retired),
        .stat_mispred (stat_mispred)
    );
`endif
endmodule
